// File: rtl/ads1118_avg_if.sv
// ads1118_avg_if
//   Groups the ADS1118 averager's frame inputs and result outputs.
//   master : the side that drives CS/ADdata/cfg_change (SPI block or bench)
//   slave  : the averager itself
//   Signals:
//     CS          chip select from the SPI master (async to CLK_50M)
//     ADdata      16-bit signed conversion, stable while CS is low
//     cfg_change  one-cycle pulse when mux/PGA configuration changes
//     avg_data    signed averaged result
//     avg_valid   one-cycle pulse, avg_data/over_range updated
//     over_range  a sample in the reported window was full scale
//     adc_stall   no frame seen for TIMEOUT cycles
interface ads1118_avg_if;
   logic        CS;
   logic [15:0] ADdata;
   logic        cfg_change;
   logic [15:0] avg_data;
   logic        avg_valid;
   logic        over_range;
   logic        adc_stall;

   modport master (
      output CS, ADdata, cfg_change,
      input  avg_data, avg_valid, over_range, adc_stall
   );

   modport slave (
      input  CS, ADdata, cfg_change,
      output avg_data, avg_valid, over_range, adc_stall
   );
endinterface

// File: rtl/ads1118_avg.sv
// ads1118_avg
//   Boxcar averager for ADS1118 conversions. Each synchronized CS falling
//   edge captures one sample; the first DISCARD samples after reset or a
//   configuration change are dropped, then every 2^AVG_LOG2 samples produce
//   one floored average. A stall flag reports missing frames.
//   Ports:
//     CLK_50M  system clock (rising edge)
//     rst_n    synchronous active-low reset
//     bus      ads1118_avg_if.slave (CS, ADdata, cfg_change in;
//              avg_data, avg_valid, over_range, adc_stall out)
module ads1118_avg #(
   parameter int AVG_LOG2 = 3,
   parameter int DISCARD  = 2,
   parameter int TIMEOUT  = 131071
) (
   input logic           CLK_50M,
   input logic           rst_n,
   ads1118_avg_if.slave  bus
);

   localparam int ACC_W  = 16 + AVG_LOG2;
   localparam int WIN    = 1 << AVG_LOG2;
   localparam int WCNT_W = AVG_LOG2 + 1;
   localparam int STC_W  = $clog2(TIMEOUT + 1);

   localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WIN - 1);
   localparam logic [4:0]        DISC_LAST = 5'((DISCARD > 0) ? DISCARD - 1 : 0);
   localparam logic [STC_W-1:0]  ST_MAX    = STC_W'(TIMEOUT);
   localparam logic [STC_W-1:0]  ST_PRE    = STC_W'(TIMEOUT - 1);

   typedef enum logic {S_DISCARD, S_ACCUM} state_t;

   state_t                    state;
   logic                      cs_s1, cs_s2, cs_s3;
   logic                      frame_ev;
   logic [15:0]               sample;
   logic                      sample_pend;
   logic [4:0]                disc_cnt;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   sample_ext;
   logic signed [ACC_W-1:0]   sum;
   logic [15:0]               avg_next;
   logic [WCNT_W-1:0]         win_cnt;
   logic                      win_or;
   logic                      sample_fs;
   logic [15:0]               avg_data_r;
   logic                      avg_valid_r;
   logic                      over_range_r;
   logic [STC_W-1:0]          stall_cnt;
   logic                      stall_r;

   // Synchronized CS falling edge: stage 2 low while the delayed stage is high.
   assign frame_ev   = cs_s3 & ~cs_s2;
   assign sample_ext = ACC_W'(signed'(sample));
   assign sum        = acc + sample_ext;
   assign avg_next   = 16'(sum >>> AVG_LOG2);
   assign sample_fs  = (sample == 16'h7FFF) || (sample == 16'h8000);

   always_ff @(posedge CLK_50M) begin
      if (!rst_n) begin
         cs_s1        <= 1'b1;
         cs_s2        <= 1'b1;
         cs_s3        <= 1'b1;
         sample       <= '0;
         sample_pend  <= 1'b0;
         state        <= S_DISCARD;
         disc_cnt     <= '0;
         acc          <= '0;
         win_cnt      <= '0;
         win_or       <= 1'b0;
         avg_data_r   <= '0;
         avg_valid_r  <= 1'b0;
         over_range_r <= 1'b0;
         stall_cnt    <= '0;
         stall_r      <= 1'b0;
      end else begin
         cs_s1       <= bus.CS;
         cs_s2       <= cs_s1;
         cs_s3       <= cs_s2;
         avg_valid_r <= 1'b0;

         if (frame_ev)
            sample <= bus.ADdata;
         // A frame coinciding with cfg_change never becomes a sample.
         sample_pend <= frame_ev & ~bus.cfg_change;

         if (bus.cfg_change) begin
            state    <= S_DISCARD;
            disc_cnt <= '0;
            acc      <= '0;
            win_cnt  <= '0;
            win_or   <= 1'b0;
         end else begin
            case (state)
               S_DISCARD: begin
                  if (DISCARD == 0) begin
                     state <= S_ACCUM;
                  end else if (sample_pend) begin
                     disc_cnt <= disc_cnt + 5'd1;
                     if (disc_cnt == DISC_LAST)
                        state <= S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  if (sample_pend) begin
                     if (win_cnt == WIN_LAST) begin
                        avg_data_r   <= avg_next;
                        avg_valid_r  <= 1'b1;
                        over_range_r <= win_or | sample_fs;
                        acc          <= '0;
                        win_cnt      <= '0;
                        win_or       <= 1'b0;
                     end else begin
                        acc     <= sum;
                        win_cnt <= win_cnt + 1'b1;
                        win_or  <= win_or | sample_fs;
                     end
                  end
               end
               default: state <= S_DISCARD;
            endcase
         end

         // stall_r tracks (stall_cnt == TIMEOUT) one register earlier.
         if (frame_ev) begin
            stall_cnt <= '0;
            stall_r   <= 1'b0;
         end else if (stall_cnt != ST_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
            stall_r   <= (stall_cnt == ST_PRE);
         end
      end
   end

   assign bus.avg_data   = avg_data_r;
   assign bus.avg_valid  = avg_valid_r;
   assign bus.over_range = over_range_r;
   assign bus.adc_stall  = stall_r;

endmodule
